// File: rtl/bcd_xs3_seq_ctrl.sv
// Steps one shared BCD-to-excess-3 converter across a packed DIGITS-wide BCD word, LSD first.
// Optional range checking of input digits is enabled by defining BCD_XS3_ERR_CHECK_EN.
module bcd_xs3_seq_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic [3:0]            conv_a,
   input  logic [3:0]            conv_x,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_xs3,
   output logic                  out_err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] cap_bcd;
   logic [4*DIGITS-1:0] xs3_r;
   logic [3:0]          store_val;
   logic                accept;
   logic                last_dig;

   assign accept   = (state == IDLE) && in_valid;
   assign last_dig = (idx == LAST_IDX);

`ifdef BCD_XS3_ERR_CHECK_EN
   function automatic logic digit_bad(input logic [3:0] d);
      return d > 4'd9;
   endfunction

   // Out-of-range digits are stored as zero so the sink never sees a bogus code.
   assign store_val = digit_bad(conv_a) ? 4'b0000 : conv_x;

   logic err_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (accept) begin
         err_r <= 1'b0;
      end else if ((state == CONV) && digit_bad(conv_a)) begin
         err_r <= 1'b1;
      end
   end

   assign out_err = err_r;
`else
   assign store_val = conv_x;
   assign out_err   = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = CONV;
         CONV:    if (last_dig)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      conv_a    = 4'd0;
      if (state == CONV) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) conv_a = cap_bcd[4*i +: 4];
         end
      end
   end

   // Capture on accept, then fill one result digit per CONV cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx     <= '0;
         cap_bcd <= '0;
         xs3_r   <= '0;
      end else if (accept) begin
         idx     <= '0;
         cap_bcd <= in_bcd;
         xs3_r   <= '0;
      end else if (state == CONV) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) xs3_r[4*i +: 4] <= store_val;
         end
         idx <= last_dig ? '0 : idx + 1'b1;
      end
   end

   assign out_xs3 = xs3_r;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Scoreboard bench for bcd_xs3_seq_ctrl (DIGITS=4) with an excess-3 converter model (a+3).
module tb_bcd_xs3_seq_ctrl;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bcd;
   logic [3:0]  conv_a;
   logic [3:0]  conv_x;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_xs3;
   logic        out_err;

   int checks = 0;
   int errors = 0;
   logic [16:0] sb[$];

   bcd_xs3_seq_ctrl #(.DIGITS(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .conv_a    (conv_a),
      .conv_x    (conv_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_xs3   (out_xs3),
      .out_err   (out_err)
   );

   assign conv_x = conv_a + 4'd3;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every output handshake must match the oldest expected result.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {15'd0, out_err, out_xs3}, 32'hFFFF_FFFF);
         end else begin
            logic [16:0] e;
            e = sb.pop_front();
            chk("out_xs3", {16'd0, out_xs3}, {16'd0, e[15:0]});
            chk("out_err", {31'd0, out_err}, {31'd0, e[16]});
         end
      end
   end

   task automatic send(input logic [15:0] word, input logic [15:0] exp_xs3, input logic exp_err);
      bit ok = 0;
      in_bcd   = word;
      in_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         if (in_ready) begin
            sb.push_back({exp_err, exp_xs3});
            tick();
            ok = 1;
            break;
         end
         tick();
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         if (sb.size() == 0 && in_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int rdy_cnt;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_bcd    = 16'h0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_xs3",   {16'd0, out_xs3},   32'd0);
      chk("rst_out_err",   {31'd0, out_err},   32'd0);
      chk("rst_conv_a",    {28'd0, conv_a},    32'd0);
      reset = 1'b0;
      tick();

      // Test 1 and 6: latency and conv_a sequence
      chk("idle_conv_a", {28'd0, conv_a}, 32'd0);
      send(16'h1234, 16'h4567, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("conv_a_seq", {28'd0, conv_a}, 32'(4 - k));
         chk("conv_out_valid", {31'd0, out_valid}, 32'd0);
         tick();
      end
      chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
      chk("done_conv_a", {28'd0, conv_a}, 32'd0);
      tick();
      chk("post_idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_idle_conv_a", {28'd0, conv_a}, 32'd0);
      drain();

      // Test 2: back-to-back words, in_valid held high
      in_bcd   = 16'h0909;
      in_valid = 1'b1;
      sb.push_back({1'b0, 16'h3C3C});
      tick();
      in_bcd = 16'h0000;
      sb.push_back({1'b0, 16'h3333});
      rdy_cnt = 0;
      for (int k = 1; k <= 6; k++) begin
         if (in_ready) rdy_cnt++;
         if (k < 6) tick();
      end
      chk("tput_ready_at_6", {31'd0, in_ready}, 32'd1);
      chk("tput_ready_count", 32'(rdy_cnt), 32'd1);
      tick();
      in_valid = 1'b0;
      drain();

      // Test 3: backpressure in DONE
      out_ready = 1'b0;
      send(16'h0357, 16'h368A, 1'b0);
      tick(); tick(); tick(); tick();
      in_bcd   = 16'h9999;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
         chk("bp_out_xs3",   {16'd0, out_xs3},   32'h368A);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      drain();

      // Test 4: out-of-range digit
`ifdef BCD_XS3_ERR_CHECK_EN
      send(16'h12A4, 16'h4507, 1'b1);
`else
      send(16'h12A4, 16'h45D7, 1'b0);
`endif
      drain();
      send(16'h9870, 16'hCBA3, 1'b0);
      drain();

      // Test 5: reset during CONV aborts the word
      send(16'h9876, 16'hCBA9, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_out_xs3",   {16'd0, out_xs3},   32'd0);
      chk("abort_out_err",   {31'd0, out_err},   32'd0);
      chk("abort_conv_a",    {28'd0, conv_a},    32'd0);
      send(16'h5555, 16'h8888, 1'b0);
      drain();
      tick();
      tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
